audio_controller: RTL and testbench
===================================

// Module: audio_controller
// PURPOSE
// - Streaming bridge between user logic and a WM8731-class codec running as serial-bus master (codec drives BCLK/LRCKs).
// - Deserialises ADC audio into left/right input FIFOs; serialises user samples from left/right output FIFOs onto DACDAT.
// - Generates codec master clock AUD_XCK. Codec register setup is done by a separate I2C config block, not here.
// PARAMETERS
// - AUDIO_DATA_WIDTH  32   bits per channel sample, both directions
// - FIFO_DEPTH        128  words per channel FIFO (power of 2); four FIFOs: in-L, in-R, out-L, out-R
// - XCK_DIV           4    CLOCK_50 divide ratio for AUD_XCK (even, >=2); 50 MHz/4 = 12.5 MHz
// PORTS
// - CLOCK_50                 in   1   system clock, all logic on rising edge
// - reset                    in   1   asynchronous, active-low reset
// - clear_audio_in_memory    in   1   sync, active-high: empty both input FIFOs
// - read_audio_in            in   1   pop one sample from each input FIFO
// - clear_audio_out_memory   in   1   sync, active-high: empty both output FIFOs
// - left_channel_audio_out   in   32  left sample to play
// - right_channel_audio_out  in   32  right sample to play
// - write_audio_out          in   1   push L/R pair into output FIFOs
// - AUD_ADCDAT               in   1   codec ADC serial data
// - AUD_BCLK                 inout 1  bit clock; never driven (held 'z'), used as input
// - AUD_ADCLRCK              inout 1  ADC frame clock; never driven, input only
// - AUD_DACLRCK              inout 1  DAC frame clock; never driven, input only
// - audio_in_available       out  1   both input FIFOs non-empty
// - left_channel_audio_in    out  32  head of left input FIFO (show-ahead)
// - right_channel_audio_in   out  32  head of right input FIFO (show-ahead)
// - audio_out_allowed        out  1   both output FIFOs not full
// - AUD_XCK                  out  1   codec master clock, 50% duty
// - AUD_DACDAT               out  1   DAC serial data
// BEHAVIOUR
// - Reset: all FIFOs empty, shift regs/counters 0; audio_in_available=0, audio_out_allowed=1, *_audio_in=0, AUD_XCK=0, AUD_DACDAT=0.
// - BCLK/ADCLRCK/DACLRCK pass 2-flop synchronisers; edge detect in CLOCK_50 domain (2-cycle detect latency). Requires BCLK <= CLOCK_50/4.
// - Format: left-justified, MSB first; LRCK high = left, low = right. Bits sampled on BCLK rising, driven on BCLK falling.
// - ADC: each LRCK edge starts a channel word, bit counter = AUDIO_DATA_WIDTH-1; rising BCLK shifts ADCDAT in while counter valid.
//   Fewer BCLKs than width: remaining LSBs 0. Extra BCLKs ignored.
// - ADC: on LRCK edge, completed word pushed to FIFO of the channel just finished; if that FIFO full, word dropped. First partial word after reset discarded.
// - read_audio_in with audio_in_available=1 pops both input FIFOs same cycle; with =0 ignored. Head data valid whenever available=1.
// - write_audio_out with audio_out_allowed=1 pushes both out FIFOs same cycle; with =0 ignored (pair discarded).
// - DAC: on DACLRCK edge, load shifter from head of new channel's out FIFO and pop it; if empty, load 0 (silence, no pop).
//   MSB on AUD_DACDAT immediately after load; shift on each BCLK falling edge; 0 after all bits sent.
// - Simultaneous push+pop on one FIFO in one cycle: both occur, count unchanged. Clear has priority over push/pop that cycle.
// - Clear does not abort a word in flight in the shifters.
// - AUD_XCK: free-running toggle every XCK_DIV/2 CLOCK_50 cycles, independent of FIFOs.
// - Reset mid-frame: all state cleared asynchronously; resume at next LRCK edge.
// TESTING
// - Reset: assert reset=0 -> available=0, allowed=1, DACDAT=0, XCK=0; release -> XCK toggles every 2 clocks.
// - ADC: codec model sends L=32'hA5A5_0001, R=32'h0000_FFFF -> available=1, outputs show those values; read -> available=0.
// - DAC: write L=32'h8000_0001, R=32'h7FFF_FFFE -> DACDAT bit streams match MSB-first per LRCK phase; empty FIFO -> 32 zeros.
// - Full: write FIFO_DEPTH pairs with no frames -> allowed=0; extra write ignored; one DAC frame pops -> allowed=1.
// - Overflow/clear: 130 ADC frames without read -> first 128 kept, rest dropped; clear_audio_in_memory -> available=0 next cycle.
// - Simultaneous: write_audio_out on same cycle as DAC pop at count 1 -> count stays 1, correct ordering.

Source files
------------

// File: rtl/audio_controller.sv
// Streaming bridge to a WM8731-class codec in bus-master mode: ADC words are
// deserialised into L/R input FIFOs, DAC words are serialised from L/R output FIFOs.

module audio_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero while empty so the show-ahead output is clean after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module audio_controller #(
    parameter int AUDIO_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 128,
    parameter int XCK_DIV          = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        clear_audio_in_memory,
    input  logic                        read_audio_in,
    input  logic                        clear_audio_out_memory,
    input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                        write_audio_out,
    input  logic                        AUD_ADCDAT,
    inout  wire                         AUD_BCLK,
    inout  wire                         AUD_ADCLRCK,
    inout  wire                         AUD_DACLRCK,
    output logic                        audio_in_available,
    output logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_in,
    output logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_in,
    output logic                        audio_out_allowed,
    output logic                        AUD_XCK,
    output logic                        AUD_DACDAT
);
    localparam int W    = AUDIO_DATA_WIDTH;
    localparam int BW   = $clog2(W);
    localparam int HALF = XCK_DIV / 2;
    localparam int XW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [2:0]    bclk_sr, adclrck_sr, daclrck_sr;
    logic [1:0]    adcdat_sr;
    logic [1:0]    prime;
    logic          sync_ok, bclk_rise, bclk_fall, adc_edge, dac_edge;
    logic [XW-1:0] xck_cnt;

    logic [W-1:0]  adc_shift;
    logic [BW-1:0] adc_bit;
    logic          adc_busy, adc_armed, adc_left;
    logic [W-1:0]  dac_shift;

    logic          in_l_empty, in_r_empty, in_l_full, in_r_full;
    logic          out_l_empty, out_r_empty, out_l_full, out_r_full;
    logic [W-1:0]  out_l_head, out_r_head;
    logic          in_pop, out_push, in_l_push, in_r_push, out_l_pop, out_r_pop;

    // Codec clocks pass a 2-flop synchroniser plus one history flop; edges are
    // ignored until the pipeline holds real samples so reset never fakes an edge.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            bclk_sr    <= '0;
            adclrck_sr <= '0;
            daclrck_sr <= '0;
            adcdat_sr  <= '0;
            prime      <= '0;
        end else begin
            bclk_sr    <= {bclk_sr[1:0], AUD_BCLK};
            adclrck_sr <= {adclrck_sr[1:0], AUD_ADCLRCK};
            daclrck_sr <= {daclrck_sr[1:0], AUD_DACLRCK};
            adcdat_sr  <= {adcdat_sr[0], AUD_ADCDAT};
            if (prime != 2'd3) prime <= prime + 2'd1;
        end
    end

    assign sync_ok   = (prime == 2'd3);
    assign bclk_rise = sync_ok && bclk_sr[1] && !bclk_sr[2];
    assign bclk_fall = sync_ok && !bclk_sr[1] && bclk_sr[2];
    assign adc_edge  = sync_ok && (adclrck_sr[1] ^ adclrck_sr[2]);
    assign dac_edge  = sync_ok && (daclrck_sr[1] ^ daclrck_sr[2]);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            xck_cnt <= '0;
            AUD_XCK <= 1'b0;
        end else if (xck_cnt == XW'(HALF - 1)) begin
            xck_cnt <= '0;
            AUD_XCK <= !AUD_XCK;
        end else begin
            xck_cnt <= xck_cnt + 1'b1;
        end
    end

    // ADC: a frame-clock edge closes the previous word and opens a new one;
    // the shifter starts cleared so a short word leaves its LSBs at zero.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            adc_shift <= '0;
            adc_bit   <= '0;
            adc_busy  <= 1'b0;
            adc_armed <= 1'b0;
            adc_left  <= 1'b0;
        end else if (adc_edge) begin
            adc_shift <= '0;
            adc_bit   <= BW'(W - 1);
            adc_busy  <= 1'b1;
            adc_armed <= 1'b1;
            adc_left  <= adclrck_sr[1];
        end else if (bclk_rise && adc_busy) begin
            adc_shift[adc_bit] <= adcdat_sr[1];
            if (adc_bit == '0) adc_busy <= 1'b0;
            else               adc_bit  <= adc_bit - 1'b1;
        end
    end

    assign in_l_push = adc_edge && adc_armed && adc_left;
    assign in_r_push = adc_edge && adc_armed && !adc_left;

    // DAC: the frame-clock edge wins over a coincident BCLK fall, so the MSB is
    // held for the whole first bit period; zeros shift in behind the word.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            dac_shift <= '0;
        end else if (dac_edge) begin
            dac_shift <= daclrck_sr[1] ? out_l_head : out_r_head;
        end else if (bclk_fall) begin
            dac_shift <= dac_shift << 1;
        end
    end

    assign AUD_DACDAT = dac_shift[W-1];
    assign out_l_pop  = dac_edge && daclrck_sr[1];
    assign out_r_pop  = dac_edge && !daclrck_sr[1];

    // User side: a strobe takes effect only in a cycle where its status flag is
    // high (read with audio_in_available, write with audio_out_allowed); a strobe
    // without its flag is dropped, and both channels always move together.
    assign audio_in_available = !in_l_empty && !in_r_empty;
    assign audio_out_allowed  = !out_l_full && !out_r_full;
    assign in_pop             = read_audio_in && audio_in_available;
    assign out_push           = write_audio_out && audio_out_allowed;

    audio_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_in_l (
        .clk(CLOCK_50), .rst_n(reset), .clr(clear_audio_in_memory),
        .push(in_l_push), .pop(in_pop), .din(adc_shift),
        .dout(left_channel_audio_in), .empty(in_l_empty), .full(in_l_full)
    );

    audio_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_in_r (
        .clk(CLOCK_50), .rst_n(reset), .clr(clear_audio_in_memory),
        .push(in_r_push), .pop(in_pop), .din(adc_shift),
        .dout(right_channel_audio_in), .empty(in_r_empty), .full(in_r_full)
    );

    audio_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_out_l (
        .clk(CLOCK_50), .rst_n(reset), .clr(clear_audio_out_memory),
        .push(out_push), .pop(out_l_pop), .din(left_channel_audio_out),
        .dout(out_l_head), .empty(out_l_empty), .full(out_l_full)
    );

    audio_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_out_r (
        .clk(CLOCK_50), .rst_n(reset), .clr(clear_audio_out_memory),
        .push(out_push), .pop(out_r_pop), .din(right_channel_audio_out),
        .dout(out_r_head), .empty(out_r_empty), .full(out_r_full)
    );
endmodule

// File: tb/tb_audio_controller.sv
// Directed bench for audio_controller: a simple codec model drives BCLK/LRCK/ADCDAT
// (BCLK = CLOCK_50/8) and captures DACDAT on each BCLK rise.

module tb_audio_controller;
    logic        clock_50 = 1'b0;
    logic        reset;
    logic        clear_audio_in_memory, read_audio_in, clear_audio_out_memory;
    logic [31:0] left_channel_audio_out, right_channel_audio_out;
    logic        write_audio_out, aud_adcdat;
    logic        bclk_drv, adclrck_drv, daclrck_drv;
    wire         aud_bclk, aud_adclrck, aud_daclrck;
    logic        audio_in_available, audio_out_allowed, aud_xck, aud_dacdat;
    logic [31:0] left_channel_audio_in, right_channel_audio_in;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] dac;
    logic [7:0]  xck_seen;

    assign aud_bclk    = bclk_drv;
    assign aud_adclrck = adclrck_drv;
    assign aud_daclrck = daclrck_drv;

    always #10 clock_50 = ~clock_50;

    audio_controller dut (
        .CLOCK_50(clock_50),
        .reset(reset),
        .clear_audio_in_memory(clear_audio_in_memory),
        .read_audio_in(read_audio_in),
        .clear_audio_out_memory(clear_audio_out_memory),
        .left_channel_audio_out(left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .write_audio_out(write_audio_out),
        .AUD_ADCDAT(aud_adcdat),
        .AUD_BCLK(aud_bclk),
        .AUD_ADCLRCK(aud_adclrck),
        .AUD_DACLRCK(aud_daclrck),
        .audio_in_available(audio_in_available),
        .left_channel_audio_in(left_channel_audio_in),
        .right_channel_audio_in(right_channel_audio_in),
        .audio_out_allowed(audio_out_allowed),
        .AUD_XCK(aud_xck),
        .AUD_DACDAT(aud_dacdat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock_50);
        #1;
    endtask

    task automatic write_pair(input logic [31:0] l, input logic [31:0] r);
        left_channel_audio_out  = l;
        right_channel_audio_out = r;
        write_audio_out         = 1'b1;
        wait_clk(1);
        write_audio_out         = 1'b0;
    endtask

    // One channel slot: frame clocks change with BCLK low, then nbits BCLK periods.
    // With wr set, a write strobe lands on the exact cycle the DUT pops for this slot.
    task automatic codec_chan(input logic lr, input int nbits, input logic [31:0] adc_word,
                              input logic wr, input logic [31:0] wl, input logic [31:0] wrr,
                              output logic [31:0] dac_word);
        logic [31:0] sh;
        dac_word    = '0;
        sh          = adc_word;
        adclrck_drv = lr;
        daclrck_drv = lr;
        aud_adcdat  = sh[31];
        if (wr) begin
            wait_clk(2);
            write_pair(wl, wrr);
            wait_clk(1);
        end else begin
            wait_clk(4);
        end
        for (int i = 0; i < nbits; i++) begin
            dac_word[31-i] = aud_dacdat;
            bclk_drv       = 1'b1;
            wait_clk(4);
            bclk_drv       = 1'b0;
            sh             = sh << 1;
            aud_adcdat     = sh[31];
            wait_clk(4);
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_audio_in_memory  = 1'b0;
        read_audio_in          = 1'b0;
        clear_audio_out_memory = 1'b0;
        left_channel_audio_out  = '0;
        right_channel_audio_out = '0;
        write_audio_out = 1'b0;
        aud_adcdat  = 1'b0;
        bclk_drv    = 1'b0;
        adclrck_drv = 1'b0;
        daclrck_drv = 1'b0;

        // Reset state
        wait_clk(3);
        check("rst_available", {31'b0, audio_in_available}, 32'd0);
        check("rst_allowed", {31'b0, audio_out_allowed}, 32'd1);
        check("rst_dacdat", {31'b0, aud_dacdat}, 32'd0);
        check("rst_xck", {31'b0, aud_xck}, 32'd0);
        check("rst_left_in", left_channel_audio_in, 32'd0);
        check("rst_right_in", right_channel_audio_in, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_clk(1);
            xck_seen[i] = aud_xck;
        end
        check("xck_pattern", {24'b0, xck_seen}, 32'h0000_0066);

        // ADC capture; the first edge only arms the deserialiser
        codec_chan(1'b1, 32, 32'hA5A5_0001, 1'b0, '0, '0, dac);
        check("dac_empty_l", dac, 32'd0);
        codec_chan(1'b0, 32, 32'h0000_FFFF, 1'b0, '0, '0, dac);
        check("dac_empty_r", dac, 32'd0);
        check("adc_one_side", {31'b0, audio_in_available}, 32'd0);
        codec_chan(1'b1, 0, 32'd0, 1'b0, '0, '0, dac);
        wait_clk(1);
        check("adc_available", {31'b0, audio_in_available}, 32'd1);
        check("adc_left", left_channel_audio_in, 32'hA5A5_0001);
        check("adc_right", right_channel_audio_in, 32'h0000_FFFF);
        read_audio_in = 1'b1;
        wait_clk(1);
        read_audio_in = 1'b0;
        check("read_available", {31'b0, audio_in_available}, 32'd0);
        check("read_left_zero", left_channel_audio_in, 32'd0);

        // DAC playback, right slot comes first because LRCK is currently high
        write_pair(32'h8000_0001, 32'h7FFF_FFFE);
        check("dac_allowed", {31'b0, audio_out_allowed}, 32'd1);
        codec_chan(1'b0, 32, 32'd0, 1'b0, '0, '0, dac);
        check("dac_right", dac, 32'h7FFF_FFFE);
        codec_chan(1'b1, 32, 32'd0, 1'b0, '0, '0, dac);
        check("dac_left", dac, 32'h8000_0001);
        codec_chan(1'b0, 32, 32'd0, 1'b0, '0, '0, dac);
        check("dac_silence", dac, 32'd0);

        // Push on the same cycle as a pop of a single-entry FIFO
        write_pair(32'h1234_5678, 32'h9ABC_DEF0);
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h9ABC_DEF0);
        exp_q.push_back(32'hCAFE_0001);
        exp_q.push_back(32'h0BAD_F00D);
        exp_q.push_back(32'h0000_0000);
        codec_chan(1'b1, 32, 32'd0, 1'b1, 32'hCAFE_0001, 32'h0BAD_F00D, dac);
        check("simul_l1", dac, exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            codec_chan((i % 2) == 1, 32, 32'd0, 1'b0, '0, '0, dac);
            check("simul_seq", dac, exp_q.pop_front());
        end

        // Fill the output FIFOs without any frames
        for (int i = 0; i < 128; i++) begin
            write_pair(32'h1000_0000 + i, 32'h8000_0000 + i);
        end
        check("full_allowed", {31'b0, audio_out_allowed}, 32'd0);
        write_pair(32'hDEAD_DEAD, 32'hBEEF_BEEF);
        check("full_extra", {31'b0, audio_out_allowed}, 32'd0);
        codec_chan(1'b0, 32, 32'd0, 1'b0, '0, '0, dac);
        check("full_pop_r", dac, 32'h8000_0000);
        check("full_one_side", {31'b0, audio_out_allowed}, 32'd0);
        codec_chan(1'b1, 32, 32'h00C0_FFEE, 1'b0, '0, '0, dac);
        check("full_pop_l", dac, 32'h1000_0000);
        check("full_reopen", {31'b0, audio_out_allowed}, 32'd1);

        // Clears; the left ADC word already in flight survives the input clear
        clear_audio_out_memory = 1'b1;
        wait_clk(1);
        clear_audio_out_memory = 1'b0;
        check("clr_out_allowed", {31'b0, audio_out_allowed}, 32'd1);
        check("pre_clear_avail", {31'b0, audio_in_available}, 32'd1);
        clear_audio_in_memory = 1'b1;
        wait_clk(1);
        clear_audio_in_memory = 1'b0;
        check("clr_in_avail", {31'b0, audio_in_available}, 32'd0);

        // Overflow: 130 short frames, only the first 128 of each channel kept
        codec_chan(1'b0, 8, 32'hFF00_0000, 1'b0, '0, '0, dac);
        check("clr_out_silence", dac, 32'd0);
        for (int k = 1; k < 130; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            codec_chan(1'b1, 8, {kb, 24'h0}, 1'b0, '0, '0, dac);
            codec_chan(1'b0, 8, {~kb, 24'h0}, 1'b0, '0, '0, dac);
        end
        codec_chan(1'b1, 0, 32'd0, 1'b0, '0, '0, dac);
        wait_clk(1);
        check("ovf_available", {31'b0, audio_in_available}, 32'd1);
        check("ovf_head_l", left_channel_audio_in, 32'h00C0_FFEE);
        check("ovf_head_r", right_channel_audio_in, 32'hFF00_0000);
        read_audio_in = 1'b1;
        wait_clk(127);
        read_audio_in = 1'b0;
        check("ovf_last_l", left_channel_audio_in, 32'h7F00_0000);
        check("ovf_last_r", right_channel_audio_in, 32'h8000_0000);
        check("ovf_last_avail", {31'b0, audio_in_available}, 32'd1);
        read_audio_in = 1'b1;
        wait_clk(1);
        read_audio_in = 1'b0;
        check("ovf_dropped", {31'b0, audio_in_available}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
